// File: rtl/dsp_file_server_if.sv
// Bus bundle for dsp_file_server: request levels, file select, data and status.
// master = initiator side, slave = file server side.
interface dsp_file_server_if #(
  parameter int dw = 32
);
  logic [7:0]    file_num;
  logic          file_read;
  logic          file_write;
  logic [dw-1:0] file_write_data;
  logic          file_clear;
  logic          error_clear;
  logic [dw-1:0] file_read_data;
  logic          file_active;
  logic [31:0]   rd_ptr;
  logic [31:0]   wr_ptr;
  logic          file_empty;
  logic          file_full;
  logic          underflow_error;
  logic          overflow_error;
  logic          protocol_error;

  modport master (
    output file_num, file_read, file_write,
    output file_write_data, file_clear, error_clear,
    input  file_read_data, file_active,
    input  rd_ptr, wr_ptr, file_empty, file_full,
    input  underflow_error, overflow_error, protocol_error
  );

  modport slave (
    input  file_num, file_read, file_write,
    input  file_write_data, file_clear, error_clear,
    output file_read_data, file_active,
    output rd_ptr, wr_ptr, file_empty, file_full,
    output underflow_error, overflow_error, protocol_error
  );
endinterface

// File: rtl/dsp_file_server.sv
// NUM_FILES circular word buffers served over a level request/active handshake.
// Ports: wb_clk, wb_rst (async, active-high), bus (dsp_file_server_if.slave).
module dsp_file_server #(
  parameter int dw         = 32,
  parameter int NUM_FILES  = 4,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  dsp_file_server_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int FW    = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam logic [7:0] NF8 = 8'(NUM_FILES);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] rd_p [NUM_FILES];
  logic [PW-1:0] wr_p [NUM_FILES];
  logic [dw-1:0] mem  [NUM_FILES][DEPTH];
  logic [dw-1:0] rdata;
  logic          uf, of, pe;

  logic          valid;
  logic [FW-1:0] fidx;
  logic [PW-1:0] cur_rd, cur_wr;
  logic          empty, full;
  logic          idle, req;
  logic          do_rd, do_wr;
  logic          rd_ok, wr_ok;
  logic          set_uf, set_of, set_pe;
  logic          do_clr;

  assign valid  = bus.file_num < NF8;
  assign fidx   = bus.file_num[FW-1:0];
  assign cur_rd = valid ? rd_p[fidx] : '0;
  assign cur_wr = valid ? wr_p[fidx] : '0;
  assign empty  = cur_rd == cur_wr;
  // Full: same word address, opposite lap bit.
  assign full   = (cur_rd[DEPTH_LOG2-1:0] == cur_wr[DEPTH_LOG2-1:0])
                && (cur_rd[PW-1] != cur_wr[PW-1]);

  assign idle   = state == IDLE;
  assign req    = bus.file_read | bus.file_write;
  assign do_rd  = idle & bus.file_read;
  assign do_wr  = idle & bus.file_write & ~bus.file_read;
  assign rd_ok  = do_rd & valid & ~empty;
  assign wr_ok  = do_wr & valid & ~full;
  assign set_uf = do_rd & valid & empty;
  assign set_of = do_wr & valid & full;
  assign set_pe = idle & ((req & ~valid)
                | (bus.file_read & bus.file_write));
  assign do_clr = idle & bus.file_clear & ~req & valid;

  always_ff @(posedge wb_clk) begin
    if (wr_ok)
      mem[fidx][cur_wr[DEPTH_LOG2-1:0]] <= bus.file_write_data;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
      rdata <= '0;
      uf    <= 1'b0;
      of    <= 1'b0;
      pe    <= 1'b0;
      for (int i = 0; i < NUM_FILES; i++) begin
        rd_p[i] <= '0;
        wr_p[i] <= '0;
      end
    end else begin
      // A set event in the same cycle as error_clear wins.
      uf <= set_uf | (uf & ~bus.error_clear);
      of <= set_of | (of & ~bus.error_clear);
      pe <= set_pe | (pe & ~bus.error_clear);
      unique case (state)
        IDLE: begin
          if (req)
            state <= ACCESS;
          if (do_rd)
            rdata <= rd_ok
                   ? mem[fidx][cur_rd[DEPTH_LOG2-1:0]]
                   : '0;
          if (rd_ok)
            rd_p[fidx] <= cur_rd + 1'b1;
          if (wr_ok)
            wr_p[fidx] <= cur_wr + 1'b1;
          if (do_clr) begin
            rd_p[fidx] <= '0;
            wr_p[fidx] <= '0;
          end
        end
        ACCESS: begin
          if (!req)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.file_active     = state == ACCESS;
  assign bus.file_read_data  = rdata;
  assign bus.rd_ptr          = 32'(cur_rd);
  assign bus.wr_ptr          = 32'(cur_wr);
  assign bus.file_empty      = valid ? empty : 1'b1;
  assign bus.file_full       = valid ? full : 1'b0;
  assign bus.underflow_error = uf;
  assign bus.overflow_error  = of;
  assign bus.protocol_error  = pe;
endmodule

// File: tb/tb_dsp_file_server.sv
// Scoreboard bench for dsp_file_server: queue-based file model, random traffic.
// Ports: none (instantiates dsp_file_server and its interface).
module tb_dsp_file_server;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_file_server_if #(.dw(32)) bus ();

  dsp_file_server #(
    .dw(32), .NUM_FILES(4), .DEPTH_LOG2(4)
  ) dut (
    .wb_clk(clk),
    .wb_rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] rd;
    logic [31:0] wr;
    logic        emp;
    logic        ful;
    logic        uf;
    logic        of;
    logic        pe;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each file is a FIFO of words plus lap counters.
  logic [31:0] mq [4][$];
  int rdc [4];
  int wrc [4];
  logic muf, mof, mpe;
  logic [31:0] last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      rdc[i] = 0;
      wrc[i] = 0;
    end
    muf = 0; mof = 0; mpe = 0;
    last = '0;
  endtask

  function automatic exp_t snap(input int f);
    exp_t e;
    e.data = last;
    if (f < 4) begin
      e.rd  = rdc[f];
      e.wr  = wrc[f];
      e.emp = mq[f].size() == 0;
      e.ful = mq[f].size() == 16;
    end else begin
      e.rd = 0; e.wr = 0; e.emp = 1; e.ful = 0;
    end
    e.uf = muf; e.of = mof; e.pe = mpe;
    return e;
  endfunction

  task automatic model_req(input bit r, input bit w, input int f,
                           input logic [31:0] d);
    if (r && w) mpe = 1;
    if (r) begin
      if (f >= 4) begin
        last = 0; mpe = 1;
      end else if (mq[f].size() == 0) begin
        last = 0; muf = 1;
      end else begin
        last = mq[f].pop_front();
        rdc[f] = (rdc[f] + 1) % 32;
      end
    end else if (w) begin
      if (f >= 4) mpe = 1;
      else if (mq[f].size() == 16) mof = 1;
      else begin
        mq[f].push_back(d);
        wrc[f] = (wrc[f] + 1) % 32;
      end
    end
  endtask

  task automatic wait_active(input logic lvl, input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.file_active === lvl) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: file_active got %b expected %b (timeout)",
             nm, bus.file_active, lvl);
  endtask

  task automatic req(input bit r, input bit w, input int f,
                     input logic [31:0] d);
    @(negedge clk);
    model_req(r, w, f, d);
    sb.push_back(snap(f));
    bus.file_num = 8'(f);
    bus.file_read = r;
    bus.file_write = w;
    bus.file_write_data = d;
    wait_active(1'b1, "ack_rise");
    @(posedge clk);
    #1;
    bus.file_read = 0;
    bus.file_write = 0;
    wait_active(1'b0, "ack_fall");
  endtask

  task automatic do_clear(input int f);
    @(negedge clk);
    bus.file_num = 8'(f);
    bus.file_clear = 1;
    @(negedge clk);
    bus.file_clear = 0;
    if (f < 4) begin
      mq[f].delete();
      rdc[f] = 0;
      wrc[f] = 0;
    end
  endtask

  task automatic do_errclr();
    @(negedge clk);
    bus.error_clear = 1;
    @(negedge clk);
    bus.error_clear = 0;
    muf = 0; mof = 0; mpe = 0;
  endtask

  task automatic check_idle(input int f);
    exp_t e;
    bus.file_num = 8'(f);
    #1;
    e = snap(f);
    chk("idle_rd_ptr", bus.rd_ptr, e.rd);
    chk("idle_wr_ptr", bus.wr_ptr, e.wr);
    chk("idle_empty", 32'(bus.file_empty), 32'(e.emp));
    chk("idle_full", 32'(bus.file_full), 32'(e.ful));
    chk("idle_uf", 32'(bus.underflow_error), 32'(e.uf));
    chk("idle_of", 32'(bus.overflow_error), 32'(e.of));
    chk("idle_pe", 32'(bus.protocol_error), 32'(e.pe));
  endtask

  // Monitor: pop on every rising file_active, then hold data stable.
  logic prev_act = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (bus.file_active === 1'b1 && !prev_act) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", 32'(sb.size()), 32'd1);
      end else begin
        cur = sb.pop_front();
        chk("rd_data", bus.file_read_data, cur.data);
        chk("rd_ptr", bus.rd_ptr, cur.rd);
        chk("wr_ptr", bus.wr_ptr, cur.wr);
        chk("empty", 32'(bus.file_empty), 32'(cur.emp));
        chk("full", 32'(bus.file_full), 32'(cur.ful));
        chk("underflow", 32'(bus.underflow_error), 32'(cur.uf));
        chk("overflow", 32'(bus.overflow_error), 32'(cur.of));
        chk("protocol", 32'(bus.protocol_error), 32'(cur.pe));
      end
    end else if (bus.file_active === 1'b1) begin
      chk("data_stable", bus.file_read_data, cur.data);
    end
    prev_act <= bus.file_active === 1'b1;
  end

  initial begin
    bus.file_num = 0;
    bus.file_read = 0;
    bus.file_write = 0;
    bus.file_write_data = 0;
    bus.file_clear = 0;
    bus.error_clear = 0;
    model_reset();
    #2;
    chk("rst_active", 32'(bus.file_active), 32'd0);
    chk("rst_data", bus.file_read_data, 32'd0);
    check_idle(0);
    @(negedge clk);
    rst = 0;

    // Two words through file 1.
    req(0, 1, 1, 32'h11111111);
    req(0, 1, 1, 32'h22222222);
    req(1, 0, 1, 0);
    req(1, 0, 1, 0);
    check_idle(1);

    // Overfill file 0.
    for (int i = 0; i < 17; i++) begin
      req(0, 1, 0, $urandom);
      if (i == 15) check_idle(0);
    end
    check_idle(0);
    chk("of_wr_ptr", bus.wr_ptr, 32'd16);
    do_errclr();

    // Empty read of file 2, then clear the sticky flag.
    req(1, 0, 2, 0);
    check_idle(2);
    do_errclr();
    check_idle(2);

    // Pointer wrap on file 3.
    for (int i = 0; i < 16; i++) req(0, 1, 3, $urandom);
    for (int i = 0; i < 16; i++) req(1, 0, 3, 0);
    for (int i = 0; i < 16; i++) req(0, 1, 3, $urandom);
    check_idle(3);
    chk("wrap_wr_ptr", bus.wr_ptr, 32'd0);
    chk("wrap_rd_ptr", bus.rd_ptr, 32'd16);
    chk("wrap_full", 32'(bus.file_full), 32'd1);

    // Protocol errors.
    req(1, 0, 7, 0);
    check_idle(7);
    do_errclr();
    req(0, 1, 7, 32'hdeadbeef);
    check_idle(7);
    do_errclr();
    req(1, 1, 0, 32'hcafef00d);
    check_idle(0);
    do_errclr();

    // Reset during ACCESS.
    @(negedge clk);
    model_req(0, 1, 1, 32'h55aa55aa);
    sb.push_back(snap(1));
    bus.file_num = 1;
    bus.file_write = 1;
    bus.file_write_data = 32'h55aa55aa;
    wait_active(1'b1, "rst_ack_rise");
    #3;
    rst = 1;
    #1;
    chk("rst_abort_active", 32'(bus.file_active), 32'd0);
    chk("rst_abort_rd_ptr", bus.rd_ptr, 32'd0);
    chk("rst_abort_wr_ptr", bus.wr_ptr, 32'd0);
    bus.file_write = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
    req(0, 1, 1, 32'h01234567);
    req(1, 0, 1, 0);
    check_idle(1);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int k, f;
      k = $urandom_range(0, 19);
      f = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
      if (k < 8) req(1, 0, f, 0);
      else if (k < 16) req(0, 1, f, $urandom);
      else if (k == 16) req(1, 1, f, $urandom);
      else if (k == 17) do_clear(f);
      else if (k == 18) do_errclr();
      else check_idle(f);
    end
    check_idle(0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
